regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the MIPS_CPU register file. Provides two registered read ports and one write port, with an optional hardwired zero register. A per-register scoreboard of pending writes flags operands whose producer has not yet written back. Sits between decode (read and issue) and writeback in the multicycle/pipelined MIPS datapath.

Parameters:
DATA_W, 32, width of each register in bits.
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W entries (default 16).
ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never pending.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
rd_req  input  1  read request; samples rs/rt at posedge.
rs  input  ADDR_W  read port A address.
rt  input  ADDR_W  read port B address.
A  output  DATA_W  registered read data, port A.
B  output  DATA_W  registered read data, port B.
rd_valid  output  1  high for exactly one cycle after each accepted rd_req.
a_busy  output  1  registered; rs was pending when sampled.
b_busy  output  1  registered; rt was pending when sampled.
we  input  1  writeback enable.
rd  input  ADDR_W  writeback address.
dataIn  input  DATA_W  writeback data.
iss_en  input  1  issue: marks iss_addr pending.
iss_addr  input  ADDR_W  destination register of the issued instruction.
pend_cnt  output  ADDR_W+1  number of currently pending registers.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: rst high clears, immediately and independent of clk:
  - all DEPTH entries to 0;
  - all pending bits to 0;
  - A, B to 0;
  - rd_valid, a_busy, b_busy to 0;
  - pend_cnt to 0.
- Reset mid-operation: reset asserted mid-operation discards any in-flight read (rd_valid 0 next cycle) and all pending state.
- Write:
  - At posedge with we=1, entry[rd] <= dataIn.
  - If ZERO_REG=1 and rd=0, the write is dropped.
  - A write clears pending[rd], whether or not the register was pending.
- Read:
  - At posedge with rd_req=1: A <= entry[rs], B <= entry[rt], a_busy <= pending[rs], b_busy <= pending[rt], rd_valid <= 1.
  - With rd_req=0: rd_valid <= 0, and A/B/a_busy/b_busy hold their values.
  - Latency is 1 cycle. Back-to-back requests are accepted every cycle.
- Same-edge read/write collision (no bypass): the read returns the old entry value and the old pending bit.
- Zero register: if ZERO_REG=1 and an address is 0, the corresponding output is 0 and its busy flag is 0.
- Scoreboard:
  - At posedge with iss_en=1 (and iss_addr!=0 when ZERO_REG=1), pending[iss_addr] <= 1.
  - Simultaneous iss_en and we to the same address: set wins; pending stays 1 because a new producer is in flight.
  - Simultaneous iss_en and we to different addresses: both apply.
  - Re-issuing an already pending register leaves it pending and does not change pend_cnt.
- pend_cnt:
  - Registered population count of the pending bits after the edge's updates.
  - Range 0..DEPTH (DEPTH-1 when ZERO_REG=1).
  - Never wraps: width ADDR_W+1 covers DEPTH.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: on a same-edge read/write collision (we=1, rd equal to rs or rt, and the write not dropped), the matching output takes dataIn and its busy flag is 0. This holds unless iss_en also targets that address on the same edge, in which case busy is 1.
- Not defined: the read returns the pre-write value and the pre-write pending bit, as stated under Behaviour.

Test Plan:
- Reset, then assert rd_req with rs=3, rt=7 -> next cycle A=0, B=0, rd_valid=1, a_busy=0, b_busy=0, pend_cnt=0.
- Write entry 5 = 0xDEADBEEF at one edge, then read rs=5 at the following edge -> A=0xDEADBEEF one cycle later. With ZERO_REG=1, write entry 0 = 0x1234 -> a read of entry 0 returns 0.
- Issue 9 -> pend_cnt=1. Read rs=9 -> a_busy=1. Write 9 = 0x55 -> pend_cnt=0. Read rs=9 -> A=0x55, a_busy=0.
- Same edge: iss_en with iss_addr=4, and we with rd=4, dataIn=0xAA -> entry 4 = 0xAA, pending[4]=1, pend_cnt=1.
- Same edge: read rs=6 and write 6 = 0x77 while entry 6 holds 0x11 and 6 is pending:
  - without REGFILE_BYPASS_EN -> A=0x11, a_busy=1;
  - with REGFILE_BYPASS_EN -> A=0x77, a_busy=0.
- Issue registers 1, 2 and 3, then assert rst asynchronously between edges -> all outputs and pend_cnt are 0 before the next posedge, and a subsequent read of 1 returns 0, not busy.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, one write port, optional hardwired
// zero entry and a pending-write scoreboard. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              rd_valid,
    output logic              a_busy,
    output logic              b_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              valid_q;
    logic              write_ok, iss_ok;
    logic [ADDR_W-1:0] raddr [2];

    assign write_ok = we && !((ZERO_REG != 0) && (rd == '0));
    assign iss_ok   = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
    assign raddr[0] = rs;
    assign raddr[1] = rt;

    // Issue is applied after writeback so a new producer keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        if (write_ok) pend_d[rd] = 1'b0;
        if (iss_ok)   pend_d[iss_addr] = 1'b1;
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            valid_q <= rd_req;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (write_ok && (rd == ADDR_W'(gi))) begin
                    mem_q[gi] <= dataIn;
                end
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data_q, data_d;
            logic              busy_q, busy_d;

            always_comb begin
                data_d = data_q;
                busy_d = busy_q;
                if (rd_req) begin
                    if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
                        data_d = '0;
                        busy_d = 1'b0;
                    end else begin
                        data_d = mem_q[raddr[gi]];
                        busy_d = pend_q[raddr[gi]];
`ifdef REGFILE_BYPASS_EN
                        // Forwarded data carries the post-edge pending bit (set only by a same-edge issue).
                        if (write_ok && (rd == raddr[gi])) begin
                            data_d = dataIn;
                            busy_d = pend_d[raddr[gi]];
                        end
`endif
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    busy_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    busy_q <= busy_d;
                end
            end
        end
    endgenerate

    assign A        = g_rd[0].data_q;
    assign B        = g_rd[1].data_q;
    assign a_busy   = g_rd[0].busy_q;
    assign b_busy   = g_rd[1].busy_q;
    assign rd_valid = valid_q;
    assign pend_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, async-reset sequence,
// and randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req, we, iss_en;
    logic [3:0]  rs, rt, rd, iss_addr;
    logic [31:0] dataIn, A, B;
    logic        rd_valid, a_busy, b_busy;
    logic [4:0]  pend_cnt;

    int checks = 0;
    int passes = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rs(rs), .rt(rt),
        .A(A), .B(B), .rd_valid(rd_valid), .a_busy(a_busy), .b_busy(b_busy),
        .we(we), .rd(rd), .dataIn(dataIn), .iss_en(iss_en), .iss_addr(iss_addr),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_req;
        logic [3:0]  rs, rt;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] din;
        logic        iss_en;
        logic [3:0]  iss_addr;
        logic [31:0] ea, eb;
        logic        ev, eab, ebb;
        logic [4:0]  ecnt;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic q, logic [3:0] s, logic [3:0] t, logic w, logic [3:0] d,
                                logic [31:0] di, logic ie, logic [3:0] ia, logic [31:0] ea,
                                logic [31:0] eb, logic ev, logic eab, logic ebb, logic [4:0] ec);
        vec_t v;
        v.rd_req = q; v.rs = s; v.rt = t; v.we = w; v.rd = d; v.din = di;
        v.iss_en = ie; v.iss_addr = ia; v.ea = ea; v.eb = eb; v.ev = ev;
        v.eab = eab; v.ebb = ebb; v.ecnt = ec;
        return v;
    endfunction

    function automatic logic [71:0] pack(logic [31:0] a, logic [31:0] b, logic v,
                                         logic ab, logic bb, logic [4:0] c);
        return {a, b, v, ab, bb, c};
    endfunction

    task automatic check(input string name, input logic [71:0] exp);
        logic [71:0] act;
        act = pack(A, B, rd_valid, a_busy, b_busy, pend_cnt);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got A=%h B=%h v=%b ab=%b bb=%b cnt=%0d, expected A=%h B=%h v=%b ab=%b bb=%b cnt=%0d",
                     name, act[71:40], act[39:8], act[7], act[6], act[5], act[4:0],
                     exp[71:40], exp[39:8], exp[7], exp[6], exp[5], exp[4:0]);
        end else begin
            passes++;
        end
    endtask

    task automatic drive(input logic q, input logic [3:0] s, input logic [3:0] t, input logic w,
                         input logic [3:0] d, input logic [31:0] di, input logic ie,
                         input logic [3:0] ia);
        rd_req = q; rs = s; rt = t; we = w; rd = d; dataIn = di; iss_en = ie; iss_addr = ia;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    // Reference model state
    logic [31:0] m_mem [16];
    bit          m_pend [16];
    logic [31:0] e_a, e_b;
    logic        e_v, e_ab, e_bb;
    int          e_cnt;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        rst = 1'b0;
        check("reset_state", pack(0, 0, 0, 0, 0, 0));

        tbl[0]  = mk(1, 3, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 32'h1234, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        tbl[6]  = mk(1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        tbl[7]  = mk(0, 0, 0, 1, 9, 32'h55, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[8]  = mk(1, 9, 5, 0, 0, 0, 0, 0, 32'h55, 32'hDEADBEEF, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 4, 32'hAA, 1, 4, 32'h55, 32'hDEADBEEF, 0, 0, 0, 1);
        tbl[10] = mk(1, 4, 4, 0, 0, 0, 0, 0, 32'hAA, 32'hAA, 1, 1, 1, 1);
        tbl[11] = mk(0, 0, 0, 1, 6, 32'h11, 1, 6, 32'hAA, 32'hAA, 0, 1, 1, 2);
        tbl[12] = mk(1, 6, 7, 1, 6, 32'h77, 0, 0, BYP ? 32'h77 : 32'h11, 0, 1, !BYP, 0, 1);
        tbl[13] = mk(1, 6, 4, 0, 0, 0, 0, 0, 32'h77, 32'hAA, 1, 0, 1, 1);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 1, 4, 32'hBB, 1, 15, 0, 0, 0, 0, 0, 1);
        tbl[17] = mk(1, 15, 4, 0, 0, 0, 0, 0, 0, 32'hBB, 1, 1, 0, 1);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rd_req, tbl[i].rs, tbl[i].rt, tbl[i].we, tbl[i].rd, tbl[i].din,
                  tbl[i].iss_en, tbl[i].iss_addr);
            step();
            $display("vec %0d: req=%b rs=%0d rt=%0d we=%b rd=%0d din=%h iss=%b@%0d -> A=%h B=%h cnt=%0d",
                     i, tbl[i].rd_req, tbl[i].rs, tbl[i].rt, tbl[i].we, tbl[i].rd, tbl[i].din,
                     tbl[i].iss_en, tbl[i].iss_addr, A, B, pend_cnt);
            check($sformatf("vec%0d", i), pack(tbl[i].ea, tbl[i].eb, tbl[i].ev, tbl[i].eab,
                                               tbl[i].ebb, tbl[i].ecnt));
        end

        // Asynchronous reset between edges while a read is valid and registers are pending
        drive(0, 0, 0, 0, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 1, 2); step();
        drive(1, 1, 2, 0, 0, 0, 1, 3); step();
        check("pre_reset_busy", pack(0, 0, 1, 1, 1, 4));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check("async_reset", pack(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        $display("async reset pulse applied between edges");
        drive(1, 1, 5, 0, 0, 0, 0, 0); step();
        check("post_reset_read", pack(0, 0, 1, 0, 0, 0));

        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
        e_a = 0; e_b = 0; e_v = 1; e_ab = 0; e_bb = 0; e_cnt = 0;

        for (int n = 0; n < 300; n++) begin
            logic        q, w, ie, wok, iok;
            logic [3:0]  s, t, d, ia;
            logic [31:0] di;
            q  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0);
            ie = ($urandom_range(0, 2) == 0);
            s = rand_addr(); t = rand_addr(); d = rand_addr(); ia = rand_addr();
            di = $urandom;
            drive(q, s, t, w, d, di, ie, ia);

            wok = w && (d != 0);
            iok = ie && (ia != 0);
            e_v = q;
            if (q) begin
                e_a = m_mem[s]; e_ab = m_pend[s];
                e_b = m_mem[t]; e_bb = m_pend[t];
                if (BYP && wok && d == s) begin e_a = di; e_ab = iok && (ia == s); end
                if (BYP && wok && d == t) begin e_b = di; e_bb = iok && (ia == t); end
            end
            if (wok) begin
                m_mem[d] = di;
                m_pend[d] = 1'b0;
            end
            if (iok) m_pend[ia] = 1'b1;
            e_cnt = 0;
            for (int k = 0; k < 16; k++) e_cnt += int'(m_pend[k]);

            step();
            $display("rnd %0d: req=%b rs=%0d rt=%0d we=%b rd=%0d iss=%b@%0d -> A=%h B=%h v=%b cnt=%0d",
                     n, q, s, t, w, d, ie, ia, A, B, rd_valid, pend_cnt);
            check($sformatf("rnd%0d", n), pack(e_a, e_b, e_v, e_ab, e_bb, 5'(e_cnt)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
